pulse_train_gen: RTL and testbench

Programmable pulse-train generator for the pulse_counter subsystem: on a start request it emits N single-ended pulses of configurable period and high width on `o_pulse`, then signals completion. It is the transmitting end of the pulse path. Its output feeds the edge detector and counter downstream, and serves as stimulus and loopback source for them.

---
 rtl/pulse_train_gen.sv | 166 ++++++++++++++++
 tb/tb_pulse_train_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: N pulses of period P and high width H, then a done strobe.
// Optional macro PULSE_GEN_CONT_EN: N=0 runs a continuous train until abort.
module pulse_train_gen #(
    parameter int CNT_W = 16,
    parameter int N_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_high,
    input  logic [N_W-1:0]   i_num,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [N_W-1:0]   o_cnt
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [N_W-1:0] CNT_MAX = '1;

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_phase,  w_phase_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic [CNT_W-1:0] r_high,   w_high_nxt;
    logic [N_W-1:0]   r_num,    w_num_nxt;
    logic [N_W-1:0]   r_cnt,    w_cnt_nxt;
    logic             r_pulse,  w_pulse_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_err,    w_err_nxt;

    logic [CNT_W-1:0] w_low;
    logic [CNT_W-1:0] w_phase_inc;
    logic [N_W-1:0]   w_cnt_inc;
    logic             w_num_ok;
    logic             w_legal;
    logic             w_more;

    assign w_low       = r_period - r_high;
    assign w_phase_inc = r_phase + CNT_W'(1);
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + N_W'(1);

`ifdef PULSE_GEN_CONT_EN
    // A latched N of zero means "run until aborted".
    assign w_num_ok = 1'b1;
    assign w_more   = (r_num == '0) || (r_cnt < r_num);
`else
    assign w_num_ok = (i_num != '0);
    assign w_more   = (r_cnt < r_num);
`endif

    assign w_legal = (i_period >= CNT_W'(2)) && (i_high != '0) &&
                     (i_high < i_period) && w_num_ok;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_period_nxt = r_period;
        w_high_nxt   = r_high;
        w_num_nxt    = r_num;
        w_cnt_nxt    = r_cnt;
        w_pulse_nxt  = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    if (w_legal) begin
                        // The first HIGH cycle already counts as pulse one.
                        w_state_nxt  = HIGH;
                        w_period_nxt = i_period;
                        w_high_nxt   = i_high;
                        w_num_nxt    = i_num;
                        w_cnt_nxt    = N_W'(1);
                        w_phase_nxt  = CNT_W'(1);
                        w_pulse_nxt  = 1'b1;
                        w_busy_nxt   = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            HIGH: begin
                w_busy_nxt = 1'b1;
                if (i_abort) begin
                    w_state_nxt = IDLE;
                    w_phase_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_phase == r_high) begin
                    w_state_nxt = LOW;
                    w_phase_nxt = CNT_W'(1);
                end else begin
                    w_phase_nxt = w_phase_inc;
                    w_pulse_nxt = 1'b1;
                end
            end
            LOW: begin
                w_busy_nxt = 1'b1;
                if (i_abort) begin
                    w_state_nxt = IDLE;
                    w_phase_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_phase == w_low) begin
                    if (w_more) begin
                        w_state_nxt = HIGH;
                        w_phase_nxt = CNT_W'(1);
                        w_pulse_nxt = 1'b1;
                        w_cnt_nxt   = w_cnt_inc;
                    end else begin
                        w_state_nxt = IDLE;
                        w_phase_nxt = '0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_phase_nxt = w_phase_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_num    <= '0;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_period <= w_period_nxt;
            r_high   <= w_high_nxt;
            r_num    <= w_num_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pulse  <= w_pulse_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign o_pulse = r_pulse;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_cnt   = r_cnt;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: driver pushes expected train/err records, monitor checks them.
// Honours PULSE_GEN_CONT_EN the same way the design does.
module tb_pulse_train_gen;

    localparam int CNT_W   = 16;
    localparam int N_W     = 3;
    localparam int CNT_MAX = (1 << N_W) - 1;
`ifdef PULSE_GEN_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic             i_abort;
    logic [CNT_W-1:0] i_period;
    logic [CNT_W-1:0] i_high;
    logic [N_W-1:0]   i_num;
    logic             o_pulse;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic [N_W-1:0]   o_cnt;

    pulse_train_gen #(.CNT_W(CNT_W), .N_W(N_W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_period (i_period),
        .i_high   (i_high),
        .i_num    (i_num),
        .o_pulse  (o_pulse),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err),
        .o_cnt    (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        bit done;
        int cnt;
        int busy_cycles;
        int p;
        int h;
        int due;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   model_cnt  = 0;
    int   cyc        = 0;
    int   idle_pulse = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit legal(input int p, input int h, input int n);
        return (p >= 2) && (h >= 1) && (h < p) && ((n >= 1) || CONT);
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    always @(posedge clk) cyc++;

    // ---------------- monitor ----------------
    exp_t cur;
    bit   active    = 1'b0;
    bit   prev_busy = 1'b0;
    int   idx       = 0;
    int   wave_err  = 0;

    always @(negedge rst_n) begin
        active    = 1'b0;
        prev_busy = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            active    = 1'b0;
            prev_busy = 1'b0;
        end else begin
            exp_t e;
            bit   fall;
            fall = prev_busy && !o_busy;
            if (o_err) begin
                if (sb_q.size() == 0) check("unexpected_err", 32'(o_err), 0);
                else begin
                    e = sb_q.pop_front();
                    check("err_kind", 32'(e.is_err), 1);
                    check("err_time", cyc, e.due);
                    check("err_cnt", o_cnt, e.cnt);
                    check("err_busy", o_busy, 0);
                end
            end
            if (o_busy && !prev_busy) begin
                if (sb_q.size() == 0) check("unexpected_start", 32'(o_busy), 0);
                else begin
                    cur = sb_q.pop_front();
                    check("start_kind", 32'(cur.is_err), 0);
                    check("start_time", cyc, cur.due);
                    active   = 1'b1;
                    idx      = 0;
                    wave_err = 0;
                end
            end
            if (o_busy && active) begin
                idx++;
                // Position inside the period decides the level; pulses started so far give the count.
                if (o_pulse !== (((idx - 1) % cur.p) < cur.h)) wave_err++;
                if (int'(o_cnt) != sat((idx - 1) / cur.p + 1)) wave_err++;
            end
            if (fall && active) begin
                check("train_len", idx, cur.busy_cycles);
                check("train_wave", wave_err, 0);
                check("done", o_done, cur.done);
                check("final_cnt", o_cnt, cur.cnt);
                active = 1'b0;
            end
            if (o_done && !fall) check("spurious_done", o_done, 0);
            if (!o_busy && o_pulse) idle_pulse++;
            prev_busy = o_busy;
        end
    end

    // ---------------- driver ----------------
    task automatic drive_cfg(input int p, input int h, input int n);
        i_period = CNT_W'(p);
        i_high   = CNT_W'(h);
        i_num    = N_W'(n);
    endtask

    // Called at a negedge while idle; returns at the negedge of the first idle cycle after the train.
    task automatic start_train(input int p, input int h, input int n, input int abort_at);
        exp_t e;
        int   last;
        e.is_err = 1'b0;
        e.p      = p;
        e.h      = h;
        e.due    = cyc + 1;
        if (abort_at > 0) begin
            e.busy_cycles = abort_at;
            e.done        = 1'b0;
            e.cnt         = sat((abort_at - 1) / p + 1);
        end else begin
            e.busy_cycles = n * p;
            e.done        = 1'b1;
            e.cnt         = sat(n);
        end
        sb_q.push_back(e);
        model_cnt = e.cnt;
        last      = e.busy_cycles;
        drive_cfg(p, h, n);
        i_start = 1'b1;
        i_abort = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= last; c++) begin
            // Mid-train noise on start and config must be ignored.
            i_start  = ($urandom_range(0, 3) == 0);
            i_period = CNT_W'($urandom);
            i_high   = CNT_W'($urandom);
            i_num    = N_W'($urandom);
            i_abort  = (c == abort_at);
            @(negedge clk);
        end
        i_start = 1'b0;
        i_abort = 1'b0;
    endtask

    task automatic rejected_start(input int p, input int h, input int n);
        exp_t e;
        e.is_err      = 1'b1;
        e.done        = 1'b0;
        e.cnt         = model_cnt;
        e.busy_cycles = 0;
        e.p           = 1;
        e.h           = 0;
        e.due         = cyc + 1;
        sb_q.push_back(e);
        drive_cfg(p, h, n);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic issue(input int p, input int h, input int n, input int abort_at);
        int a;
        a = abort_at;
        if (n == 0 && a == 0) a = 8 * p;
        if (legal(p, h, n)) start_train(p, h, n, a);
        else rejected_start(p, h, n);
    endtask

    task automatic idle_abort();
        drive_cfg(5, 2, 3);
        i_start = 1'b1;
        i_abort = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        drive_cfg(0, 0, 0);
        #1;
        check("rst_pulse", o_pulse, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_cnt", o_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        start_train(5, 2, 3, 0);        // back-to-back follow-up below
        issue(3, 1, 2, 0);
        repeat (2) @(negedge clk);
        issue(4, 4, 2, 0);
        issue(1, 1, 2, 0);
        issue(5, 0, 2, 0);
        @(negedge clk);
        issue(10, 3, 5, 13);
        @(negedge clk);
        issue(3, 1, 0, 30);
        @(negedge clk);
        idle_abort();
        @(negedge clk);

        for (int t = 0; t < 80; t++) begin
            int p, h, n, a;
            p = $urandom_range(1, 7);
            h = $urandom_range(0, p);
            n = $urandom_range(0, CNT_MAX);
            a = 0;
            if (legal(p, h, n) && (n == 0 || $urandom_range(0, 3) == 0))
                a = $urandom_range(1, (n == 0) ? 10 * p : n * p);
            issue(p, h, n, a);
            if ($urandom_range(0, 5) == 0) idle_abort();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Asynchronous reset in the middle of a HIGH phase.
        begin
            exp_t e;
            e.is_err      = 1'b0;
            e.done        = 1'b0;
            e.cnt         = 0;
            e.busy_cycles = 0;
            e.p           = 4;
            e.h           = 3;
            e.due         = cyc + 1;
            sb_q.push_back(e);
        end
        drive_cfg(4, 3, 7);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_cnt = 0;
        check("async_rst_pulse", o_pulse, 0);
        check("async_rst_busy", o_busy, 0);
        check("async_rst_done", o_done, 0);
        check("async_rst_err", o_err, 0);
        check("async_rst_cnt", o_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_pulse", o_pulse, 0);
        check("post_rst_busy", o_busy, 0);
        issue(1, 1, 1, 0);

        repeat (5) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        check("idle_pulse", idle_pulse, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
